dlock_ctrl: RTL and testbench
=============================

Name: dlock_ctrl

Overview:
Attempt manager sitting directly downstream of the serial "101100" lock detector. It consumes the detector's unlock output together with a per-bit strobe, frames entries into 6-bit attempts, and drives a timed door-open output. It counts failed attempts, enforces a timed lockout with an alarm pulse, and re-initialises the detector through an active-low clear after each attempt.

Parameters:
CODE_LEN, 6, bits per attempt; must be >= 2
MAX_FAIL, 3, consecutive failed attempts that trigger lockout; range 1..7
OPEN_CYCLES, 16, clk cycles door_open stays high
LOCK_CYCLES, 64, clk cycles lockout lasts
TIMEOUT_CYCLES, 32, idle cycles before a partial entry is abandoned (optional feature only)

Ports:
clk  input  1  system clock; all logic on the rising edge
clear  input  1  synchronous, active-high reset
bit_stb  input  1  one-cycle pulse: the detector accepted one b_in bit this cycle
unlock  input  1  detector unlock output; sampled only when bit_stb=1
door_open  output  1  high while the door is released
lockout  output  1  high during lockout
alarm  output  1  one-cycle pulse on entry to LOCKOUT
det_clr_n  output  1  active-low clear to the detector; one-cycle low pulse
fail_cnt  output  3  consecutive failed attempts so far
bit_cnt  output  3  bits received in the current attempt

Behaviour:
- clear=1 at a rising edge: state=IDLE; door_open=0, lockout=0, alarm=0, fail_cnt=0, bit_cnt=0, timers=0; det_clr_n=0 in the cycle after reset, then 1.
- All outputs are registered. Every event takes effect on the edge after it is sampled.
- IDLE:
  - bit_stb&unlock -> OPEN.
  - bit_stb&!unlock -> ENTRY with bit_cnt=1.
  - unlock without bit_stb is ignored in every state.
- ENTRY:
  - bit_stb&unlock -> OPEN. This holds even when bit_cnt<CODE_LEN-1, because overlapping detector matches count.
  - bit_stb&!unlock with bit_cnt<CODE_LEN-1 -> bit_cnt+1.
  - bit_stb&!unlock with bit_cnt==CODE_LEN-1 -> failed attempt:
    - bit_cnt=0 and det_clr_n pulses low for one cycle.
    - If fail_cnt+1==MAX_FAIL -> LOCKOUT with fail_cnt=MAX_FAIL.
    - Otherwise -> IDLE with fail_cnt+1.
- OPEN:
  - door_open=1 for exactly OPEN_CYCLES cycles. fail_cnt=0 and bit_cnt=0 on entry.
  - bit_stb is ignored.
  - On expiry: door_open=0, det_clr_n low for one cycle, -> IDLE.
- LOCKOUT:
  - lockout=1 for exactly LOCK_CYCLES cycles.
  - alarm=1 only in the first of those cycles.
  - bit_stb is ignored.
  - On expiry: lockout=0, fail_cnt=0, det_clr_n low for one cycle, -> IDLE.
- door_open and lockout are never high together.
- Timers are down-counters loaded on state entry. Each timer is sized $clog2 of its parameter + 1; no wrap.
- fail_cnt saturates at MAX_FAIL and never wraps.
- clear asserted mid-OPEN or mid-LOCKOUT aborts immediately to the reset values; no alarm is produced.
- A det_clr_n pulse and a bit_stb in the same cycle: the bit is still counted by this block. Upstream sequencing guarantees no bit_stb in the cycle after det_clr_n.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: in ENTRY, a counter reloads to TIMEOUT_CYCLES on every bit_stb. If it reaches 0 with no bit_stb, the partial entry counts as a failed attempt: same fail_cnt, LOCKOUT and det_clr_n rules as above, and bit_cnt=0.
- Undefined: ENTRY waits indefinitely. No timeout counter is synthesised, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset: assert clear for 2 cycles -> all outputs 0 and fail_cnt=0; det_clr_n low for exactly 1 cycle after release.
- Correct code: 6 strobes with unlock=1 on the 6th -> door_open=1 on the next edge for exactly 16 cycles; fail_cnt=0; det_clr_n pulse at expiry; state back to IDLE.
- Three wrong 6-bit attempts (unlock=0 throughout) -> fail_cnt 1, 2, then lockout=1 for 64 cycles; alarm high for 1 cycle; strobes during lockout leave bit_cnt=0; fail_cnt=0 after expiry.
- Two failures, then a correct attempt -> door_open=1 and fail_cnt resets to 0; a later single failure gives fail_cnt=1, with no lockout.
- clear pulsed at cycle 5 of OPEN and at cycle 10 of LOCKOUT -> door_open/lockout drop on the next edge; no alarm.
- ENTRY_TIMEOUT_EN defined: 3 strobes, then 32 idle cycles -> fail_cnt=1, bit_cnt=0, det_clr_n pulse; a strobe every 31 cycles never times out.

Source files
------------

// File: rtl/dlock_ctrl.sv
// Purpose : attempt manager behind the serial "101100" lock detector; frames
//           detector bits into CODE_LEN-bit attempts, drives a timed door
//           release, counts failures and enforces a timed lockout.
// Latency : every output is registered; each event appears one edge after
//           it is sampled.
// Backpressure: none; bit_stb is a fire-and-forget strobe, and it is dropped
//           while the door is open or the block is locked out.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset
//   bit_stb    one-cycle strobe: detector accepted one bit this cycle
//   unlock     detector match output, only looked at together with bit_stb
//   door_open  high while the door is released (OPEN_CYCLES cycles)
//   lockout    high while locked out (LOCK_CYCLES cycles)
//   alarm      one-cycle pulse in the first lockout cycle
//   det_clr_n  active-low one-cycle clear pulse back to the detector
//   fail_cnt   consecutive failed attempts, saturates at MAX_FAIL
//   bit_cnt    bits received in the current attempt
//
// Build option: define ENTRY_TIMEOUT_EN to abandon a partial entry that sees
// no bit_stb for TIMEOUT_CYCLES cycles (counted as a failed attempt).
module dlock_ctrl #(
    parameter int CODE_LEN       = 6,
    parameter int MAX_FAIL       = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCK_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       bit_stb,
    input  logic       unlock,
    output logic       door_open,
    output logic       lockout,
    output logic       alarm,
    output logic       det_clr_n,
    output logic [2:0] fail_cnt,
    output logic [2:0] bit_cnt
);

    localparam int OPEN_W = $clog2(OPEN_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
    localparam logic [2:0] LAST_BIT = 3'(CODE_LEN - 1);
    localparam logic [3:0] MAX_F4   = 4'(MAX_FAIL);

    // Parameter sanity, evaluated at elaboration only.
    if (CODE_LEN < 2 || CODE_LEN > 8) begin : g_bad_code_len
        $error("dlock_ctrl: CODE_LEN must be in 2..8");
    end
    if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
        $error("dlock_ctrl: MAX_FAIL must be in 1..7");
    end
    if (OPEN_CYCLES < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("dlock_ctrl: cycle counts must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_OPEN  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t            state,     state_nxt;
    logic              door_nxt,  lock_nxt, alarm_nxt, clr_n_nxt;
    logic [2:0]        fail_nxt,  bit_nxt;
    logic [OPEN_W-1:0] open_tmr,  open_tmr_nxt;
    logic [LOCK_W-1:0] lock_tmr,  lock_tmr_nxt;
    logic              go_open,   fail_ev;
    logic [3:0]        fail_inc;
`ifdef ENTRY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0]  tmo_tmr,   tmo_tmr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= S_IDLE;
            door_open <= 1'b0;
            lockout   <= 1'b0;
            alarm     <= 1'b0;
            det_clr_n <= 1'b0;  // detector is cleared in the cycle after reset
            fail_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            open_tmr  <= '0;
            lock_tmr  <= '0;
`ifdef ENTRY_TIMEOUT_EN
            tmo_tmr   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            door_open <= door_nxt;
            lockout   <= lock_nxt;
            alarm     <= alarm_nxt;
            det_clr_n <= clr_n_nxt;
            fail_cnt  <= fail_nxt;
            bit_cnt   <= bit_nxt;
            open_tmr  <= open_tmr_nxt;
            lock_tmr  <= lock_tmr_nxt;
`ifdef ENTRY_TIMEOUT_EN
            tmo_tmr   <= tmo_tmr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        door_nxt     = door_open;
        lock_nxt     = lockout;
        alarm_nxt    = 1'b0;
        clr_n_nxt    = 1'b1;
        fail_nxt     = fail_cnt;
        bit_nxt      = bit_cnt;
        open_tmr_nxt = open_tmr;
        lock_tmr_nxt = lock_tmr;
        go_open      = 1'b0;
        fail_ev      = 1'b0;
        fail_inc     = {1'b0, fail_cnt} + 4'd1;
`ifdef ENTRY_TIMEOUT_EN
        tmo_tmr_nxt  = tmo_tmr;
`endif

        case (state)
            S_IDLE: begin
                if (bit_stb) begin
                    if (unlock) begin
                        go_open = 1'b1;
                    end else begin
                        state_nxt = S_ENTRY;
                        bit_nxt   = 3'd1;
`ifdef ENTRY_TIMEOUT_EN
                        tmo_tmr_nxt = TMO_W'(TIMEOUT_CYCLES);
`endif
                    end
                end
            end
            S_ENTRY: begin
                if (bit_stb) begin
                    // A match may complete before CODE_LEN bits because the
                    // detector reports overlapping matches.
                    if (unlock) begin
                        go_open = 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        fail_ev = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
`ifdef ENTRY_TIMEOUT_EN
                        tmo_tmr_nxt = TMO_W'(TIMEOUT_CYCLES);
`endif
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (tmo_tmr == TMO_W'(1)) begin
                    fail_ev = 1'b1;
                end else begin
                    tmo_tmr_nxt = tmo_tmr - TMO_W'(1);
                end
`endif
            end
            S_OPEN: begin
                // Timer holds the cycles still to run including this one.
                if (open_tmr == OPEN_W'(1)) begin
                    door_nxt  = 1'b0;
                    clr_n_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    open_tmr_nxt = open_tmr - OPEN_W'(1);
                end
            end
            S_LOCK: begin
                if (lock_tmr == LOCK_W'(1)) begin
                    lock_nxt  = 1'b0;
                    fail_nxt  = 3'd0;
                    clr_n_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    lock_tmr_nxt = lock_tmr - LOCK_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (go_open) begin
            state_nxt    = S_OPEN;
            door_nxt     = 1'b1;
            open_tmr_nxt = OPEN_W'(OPEN_CYCLES);
            fail_nxt     = 3'd0;
            bit_nxt      = 3'd0;
        end

        if (fail_ev) begin
            bit_nxt   = 3'd0;
            clr_n_nxt = 1'b0;
            // >= keeps the count pinned at MAX_FAIL rather than wrapping.
            if (fail_inc >= MAX_F4) begin
                state_nxt    = S_LOCK;
                fail_nxt     = MAX_F4[2:0];
                lock_nxt     = 1'b1;
                alarm_nxt    = 1'b1;
                lock_tmr_nxt = LOCK_W'(LOCK_CYCLES);
            end else begin
                state_nxt = S_IDLE;
                fail_nxt  = fail_inc[2:0];
            end
        end
    end

endmodule

// File: tb/tb_dlock_ctrl.sv
// Purpose : self-checking bench for dlock_ctrl against a counter-based model.
// Latency : outputs are checked 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a strobe stream.
module tb_dlock_ctrl;

    localparam int CODE_LEN       = 6;
    localparam int MAX_FAIL       = 3;
    localparam int OPEN_CYCLES    = 16;
    localparam int LOCK_CYCLES    = 64;
    localparam int TIMEOUT_CYCLES = 32;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       bit_stb = 1'b0;
    logic       unlock = 1'b0;
    logic       door_open, lockout, alarm, det_clr_n;
    logic [2:0] fail_cnt, bit_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining-cycle counters and an attempt length.
    // Being "in an entry" is simply m_bits > 0.
    int m_open  = 0;
    int m_lock  = 0;
    int m_bits  = 0;
    int m_fails = 0;
    int m_idle  = 0;
    bit m_clr_n = 1'b0;
    bit m_alarm = 1'b0;

    dlock_ctrl #(
        .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_CYCLES),
        .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .clear(clear), .bit_stb(bit_stb), .unlock(unlock),
        .door_open(door_open), .lockout(lockout), .alarm(alarm),
        .det_clr_n(det_clr_n), .fail_cnt(fail_cnt), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Packed view: {door_open, lockout, alarm, det_clr_n, fail_cnt, bit_cnt}
    function automatic logic [9:0] dut_vec();
        return {door_open, lockout, alarm, det_clr_n, fail_cnt, bit_cnt};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {logic'(m_open > 0), logic'(m_lock > 0), logic'(m_alarm),
                logic'(m_clr_n), 3'(m_fails), 3'(m_bits)};
    endfunction

    task automatic record_fail();
        m_bits  = 0;
        m_idle  = 0;
        m_clr_n = 1'b0;
        m_fails = m_fails + 1;
        if (m_fails >= MAX_FAIL) begin
            m_fails = MAX_FAIL;
            m_lock  = LOCK_CYCLES;
            m_alarm = 1'b1;
        end
    endtask

    task automatic model_step(input logic stb, input logic unl, input logic clr);
        if (clr) begin
            m_open = 0; m_lock = 0; m_bits = 0; m_fails = 0; m_idle = 0;
            m_clr_n = 1'b0; m_alarm = 1'b0;
        end else begin
            m_clr_n = 1'b1;
            m_alarm = 1'b0;
            if (m_open > 0) begin
                m_open = m_open - 1;
                if (m_open == 0) m_clr_n = 1'b0;
            end else if (m_lock > 0) begin
                m_lock = m_lock - 1;
                if (m_lock == 0) begin
                    m_fails = 0;
                    m_clr_n = 1'b0;
                end
            end else if (stb) begin
                m_idle = 0;
                if (unl) begin
                    m_open = OPEN_CYCLES; m_fails = 0; m_bits = 0;
                end else if (m_bits == CODE_LEN - 1) begin
                    record_fail();
                end else begin
                    m_bits = m_bits + 1;
                end
            end
`ifdef ENTRY_TIMEOUT_EN
            else if (m_bits > 0) begin
                m_idle = m_idle + 1;
                if (m_idle == TIMEOUT_CYCLES) record_fail();
            end
`endif
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic tick(input logic stb, input logic unl, input logic clr);
        bit_stb = stb; unlock = unl; clear = clr;
        @(posedge clk);
        model_step(stb, unl, clr);
        #1;
        bit_stb = 1'b0; unlock = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            total++;
            if (dut_vec() !== 10'b0000_000_000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, dut_vec(), 10'b0000_000_000);
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== 10'b0001_000_000) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", dut_vec(), 10'b0001_000_000);
        end
    endtask

    task automatic test_correct_code();
        int door_cycles = 0;
        int clr_low = 0;
        for (int i = 0; i < CODE_LEN; i++) begin
            tick(1'b1, logic'(i == CODE_LEN - 1), 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL code_entry cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        door_cycles = int'(door_open);
        for (int i = 0; i < OPEN_CYCLES + 2; i++) begin
            tick(logic'($urandom_range(0, 1)), 1'b0, 1'b0);  // strobes ignored while open
            if (door_open === 1'b1) door_cycles++;
            if (det_clr_n === 1'b0) clr_low++;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL open_phase cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
            if (m_open == 0 && m_bits > 0) m_bits = m_bits;  // model tracks any post-expiry strobe
        end
        total++;
        if (door_cycles != OPEN_CYCLES) begin
            bad++;
            $display("FAIL open_length got=%0d want=%0d", door_cycles, OPEN_CYCLES);
        end
        total++;
        if (clr_low != 1) begin
            bad++;
            $display("FAIL open_expiry_clr got=%0d want=%0d", clr_low, 1);
        end
        tick(1'b0, 1'b0, 1'b1);  // return to a known idle state
    endtask

    task automatic test_lockout();
        int lock_cycles = 0;
        int alarm_cycles = 0;
        for (int i = 0; i < MAX_FAIL * CODE_LEN; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrong_attempt cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
            if (i % CODE_LEN == CODE_LEN - 1) begin
                total++;
                if (fail_cnt !== 3'((i + 1) / CODE_LEN)) begin
                    bad++;
                    $display("FAIL fail_step got=%0d want=%0d", fail_cnt, (i + 1) / CODE_LEN);
                end
            end
        end
        lock_cycles  = int'(lockout);
        alarm_cycles = int'(alarm);
        for (int i = 0; i < LOCK_CYCLES + 1; i++) begin
            tick(logic'(i < LOCK_CYCLES - 4 && $urandom_range(0, 1) == 1),
                 logic'($urandom_range(0, 1)), 1'b0);
            if (lockout === 1'b1) lock_cycles++;
            if (alarm === 1'b1) alarm_cycles++;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL lock_phase cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (lock_cycles != LOCK_CYCLES || alarm_cycles != 1) begin
            bad++;
            $display("FAIL lock_length got=%0d/%0d want=%0d/1", lock_cycles, alarm_cycles, LOCK_CYCLES);
        end
        total++;
        if (fail_cnt !== 3'd0) begin
            bad++;
            $display("FAIL lock_fail_clear got=%0d want=0", fail_cnt);
        end
    endtask

    task automatic test_fail_then_open();
        for (int i = 0; i < 2 * CODE_LEN + CODE_LEN; i++) begin
            tick(1'b1, logic'(i == 3 * CODE_LEN - 1), 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fail_then_open cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (door_open !== 1'b1 || fail_cnt !== 3'd0) begin
            bad++;
            $display("FAIL open_clears_fail got=%b/%0d want=1/0", door_open, fail_cnt);
        end
        for (int i = 0; i < OPEN_CYCLES + 1 + CODE_LEN; i++) begin
            tick(logic'(i > OPEN_CYCLES), 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_fail cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (fail_cnt !== 3'd1 || lockout !== 1'b0) begin
            bad++;
            $display("FAIL single_fail_end got=%0d/%b want=1/0", fail_cnt, lockout);
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_abort();
        for (int i = 0; i < CODE_LEN + 4; i++) tick(1'b1, logic'(i == CODE_LEN - 1), 1'b0);
        tick(1'b0, 1'b0, 1'b1);  // clear during cycle 5 of OPEN
        total++;
        if (dut_vec() !== 10'b0000_000_000) begin
            bad++;
            $display("FAIL clear_open got=%b want=%b", dut_vec(), 10'b0000_000_000);
        end
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_FAIL * CODE_LEN + 9; i++) tick(logic'(i < MAX_FAIL * CODE_LEN), 1'b0, 1'b0);
        total++;
        if (lockout !== 1'b1) begin
            bad++;
            $display("FAIL lock_before_clear got=%b want=1", lockout);
        end
        tick(1'b0, 1'b0, 1'b1);  // clear during cycle 10 of LOCKOUT
        total++;
        if (dut_vec() !== 10'b0000_000_000) begin
            bad++;
            $display("FAIL clear_lock got=%b want=%b", dut_vec(), 10'b0000_000_000);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec() || alarm !== 1'b0) begin
                bad++;
                $display("FAIL post_clear cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_entry_timeout();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL idle_entry cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
`ifdef ENTRY_TIMEOUT_EN
        total++;
        if (fail_cnt !== 3'd1 || bit_cnt !== 3'd0 || det_clr_n !== 1'b0) begin
            bad++;
            $display("FAIL timeout got=%0d/%0d/%b want=1/0/0", fail_cnt, bit_cnt, det_clr_n);
        end
`else
        total++;
        if (fail_cnt !== 3'd0 || bit_cnt !== 3'd3) begin
            bad++;
            $display("FAIL no_timeout got=%0d/%0d want=0/3", fail_cnt, bit_cnt);
        end
`endif
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        // A strobe every TIMEOUT_CYCLES-1 cycles keeps the entry alive.
        for (int k = 0; k < CODE_LEN - 1; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < TIMEOUT_CYCLES - 2; i++) tick(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (fail_cnt !== 3'd0 || bit_cnt !== 3'(CODE_LEN - 1)) begin
            bad++;
            $display("FAIL keepalive got=%0d/%0d want=0/%0d", fail_cnt, bit_cnt, CODE_LEN - 1);
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            tick(logic'($urandom_range(0, 99) < 50), logic'($urandom_range(0, 99) < 12),
                 logic'($urandom_range(0, 999) < 3));
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
            total++;
            if (door_open === 1'b1 && lockout === 1'b1) begin
                bad++;
                $display("FAIL exclusive cyc=%0d got=11 want=not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_lockout();
        test_fail_then_open();
        test_clear_abort();
        test_entry_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
